ysyx_22040729_ctrl_fsm: RTL

Multi-cycle sequencer for the RV64 core. It fetches an instruction over a valid/ready handshake, holds it stable for the combinational decoder, and launches the memory access for loads and stores. It then gates the register-file write enable into a single writeback pulse and updates the PC. It also stops the core on ebreak or on an illegal encoding, and keeps a retired-instruction counter.

---
 rtl/ysyx_22040729_ctrl_fsm.sv | 103 ++++++++++
 1 files changed

// File: rtl/ysyx_22040729_ctrl_fsm.sv
// ysyx_22040729_ctrl_fsm: multi-cycle fetch/decode/mem/writeback sequencer with halt, trap and retire counting
module ysyx_22040729_ctrl_fsm #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [ADDR_WIDTH-1:0] ifu_addr,
    input  logic                  ifu_resp_valid,
    input  logic [INST_WIDTH-1:0] ifu_resp_inst,
    output logic [INST_WIDTH-1:0] inst,
    input  logic                  dec_rf_we,
    input  logic [ADDR_WIDTH-1:0] exu_next_pc,
    output logic                  lsu_req_valid,
    input  logic                  lsu_req_ready,
    output logic                  lsu_req_we,
    input  logic                  lsu_resp_valid,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  retire,
    output logic [63:0]           instret,
    output logic                  halt,
    output logic                  trap
);
    typedef enum logic [2:0] {IDLE, FETCH, FWAIT, DECODE, MEM, MWAIT, WB, HALT} state_t;
    localparam logic [INST_WIDTH-1:0] EBREAK = INST_WIDTH'(32'h0010_0073);
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [63:0] instret_q, instret_d;
    logic trap_q, trap_d;
    logic is_ebreak, is_illegal, is_load, is_store;
    assign is_ebreak  = inst_q == EBREAK;
    assign is_illegal = inst_q[1:0] != 2'b11;
    assign is_load    = inst_q[6:0] == 7'b0000011;
    assign is_store   = inst_q[6:0] == 7'b0100011;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        case (state_q)
            IDLE:   state_d = start ? FETCH : IDLE;
            FETCH: begin
                if (ifu_req_ready) begin
                    state_d = ifu_resp_valid ? DECODE : FWAIT;
                    inst_d  = ifu_resp_valid ? ifu_resp_inst : inst_q;
                end
            end
            FWAIT: begin
                if (ifu_resp_valid) begin
                    state_d = DECODE;
                    inst_d  = ifu_resp_inst;
                end
            end
            // ebreak retires here since it never reaches WB
            DECODE: begin
                state_d   = (is_ebreak || is_illegal) ? HALT : (is_load || is_store) ? MEM : WB;
                trap_d    = is_illegal;
                instret_d = is_ebreak ? instret_q + 64'd1 : instret_q;
            end
            MEM:    if (lsu_req_ready) state_d = lsu_resp_valid ? WB : MWAIT;
            MWAIT:  if (lsu_resp_valid) state_d = WB;
            WB: begin
                state_d   = FETCH;
                pc_d      = exu_next_pc;
                instret_d = instret_q + 64'd1;
            end
            default: state_d = state_q;
        endcase
    end
    assign ifu_req_valid = state_q == FETCH;
    assign ifu_addr      = pc_q;
    assign inst          = inst_q;
    assign lsu_req_valid = state_q == MEM;
    assign lsu_req_we    = (state_q == MEM) && is_store;
    assign rf_we         = (state_q == WB) && dec_rf_we && !is_store;
    assign retire        = (state_q == WB) || ((state_q == DECODE) && is_ebreak);
    assign pc            = pc_q;
    assign instret       = instret_q;
    assign halt          = state_q == HALT;
    assign trap          = trap_q;
endmodule
